// File: rtl/dcls_pkg.sv
// -----------------------------------------------------------------------------
// dcls_pkg -- shared definitions for the dual-core lock-step comparator.
//   CMP_W         : width of the packed core-output bus that is compared.
//   *_W           : widths of the individual core-output fields.
//   dcls_bus_t    : field view of the packed bus, MSB first.
//   dcls_state_e  : comparator state (ARM, CHECK, FAULT).
// -----------------------------------------------------------------------------
package dcls_pkg;

  localparam int MEM_D_ADDR_W    = 32;
  localparam int MEM_D_DATA_WR_W = 32;
  localparam int MEM_D_RD_W      = 1;
  localparam int MEM_D_WR_W      = 4;
  localparam int MEM_I_RD_W      = 1;
  localparam int MEM_I_PC_W      = 32;

  localparam int CMP_W = MEM_D_ADDR_W + MEM_D_DATA_WR_W + MEM_D_RD_W +
                         MEM_D_WR_W + MEM_I_RD_W + MEM_I_PC_W;

  // Declaration order fixes the packing: mem_d_addr occupies the MSBs and
  // mem_i_pc the LSBs, so bit 0 of the bus is the PC LSB.
  typedef struct packed {
    logic [MEM_D_ADDR_W-1:0]    mem_d_addr;
    logic [MEM_D_DATA_WR_W-1:0] mem_d_data_wr;
    logic [MEM_D_RD_W-1:0]      mem_d_rd;
    logic [MEM_D_WR_W-1:0]      mem_d_wr;
    logic [MEM_I_RD_W-1:0]      mem_i_rd;
    logic [MEM_I_PC_W-1:0]      mem_i_pc;
  } dcls_bus_t;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_CHECK = 2'd1,
    ST_FAULT = 2'd2
  } dcls_state_e;

endpackage

// File: rtl/dcls_delay_line.sv
// -----------------------------------------------------------------------------
// dcls_delay_line -- DEPTH-stage register chain, synchronous active-low reset.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset, clears every stage to zero
//   d_i    : WIDTH-bit input sampled every cycle
//   q_o    : d_i delayed by exactly DEPTH cycles (DEPTH >= 1)
// -----------------------------------------------------------------------------
module dcls_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: every stage is reset, unlike a RAM-style array; stale data from
  // before reset must never reach the comparator as a false mismatch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take its neighbour's
      // old value, giving a true shift instead of a single-cycle fall-through.
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dcls_compare.sv
// -----------------------------------------------------------------------------
// dcls_compare -- dual-core lock-step output comparator.
// The main-core bus is delayed DCLS_DELAY cycles to line up with the lagging
// shadow core, then compared bitwise every cycle once the pipeline is armed.
//   clk_i        : clock
//   rst_ni       : synchronous active-low reset
//   main_bus_i   : packed main-core outputs (dcls_bus_t layout)
//   shadow_bus_i : packed shadow-core outputs, same layout
//   err_clr_i    : clears the mismatch counter; also leaves FAULT if clean
//   inject_i     : flips the PC LSB of the delayed main bus for one compare
//                  (only with DCLS_FAULT_INJECT_EN defined, else ignored)
//   mismatch_o   : registered per-cycle mismatch flag
//   fault_o      : sticky fault flag (high in FAULT)
//   err_count_o  : saturating count of mismatch cycles
//   armed_o      : high while comparing (CHECK or FAULT)
// Build option: define DCLS_FAULT_INJECT_EN to include fault injection.
// -----------------------------------------------------------------------------
module dcls_compare
  import dcls_pkg::*;
#(
  parameter int DCLS_DELAY = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [CMP_W-1:0]     main_bus_i,
  input  logic [CMP_W-1:0]     shadow_bus_i,
  input  logic                 err_clr_i,
  input  logic                 inject_i,
  output logic                 mismatch_o,
  output logic                 fault_o,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic                 armed_o
);

  // The arm counter runs 0..DCLS_DELAY, i.e. DCLS_DELAY+1 cycles in ARM.
  localparam int                 ARM_W    = $clog2(DCLS_DELAY + 1);
  localparam logic [ARM_W-1:0]   ARM_LAST = ARM_W'(DCLS_DELAY);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  dcls_state_e      state_q;
  logic [ARM_W-1:0] arm_cnt_q;
  logic [CMP_W-1:0] main_dly;
  logic [CMP_W-1:0] main_cmp;
  logic             raw_mismatch;

  dcls_delay_line #(
    .WIDTH (CMP_W),
    .DEPTH (DCLS_DELAY)
  ) u_delay_line (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (main_bus_i),
    .q_o    (main_dly)
  );

`ifdef DCLS_FAULT_INJECT_EN
  // Bit 0 is the mem_i_pc LSB; flipping it only affects this cycle's compare.
  assign main_cmp = main_dly ^ {{(CMP_W-1){1'b0}}, inject_i};
`else
  logic unused_inject;
  assign unused_inject = inject_i;
  assign main_cmp      = main_dly;
`endif

  // NOTE: a plain continuous assignment cannot infer a latch; any always_comb
  // added here must assign every output on every path.
  assign raw_mismatch = (main_cmp != shadow_bus_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_ARM;
      arm_cnt_q   <= '0;
      mismatch_o  <= 1'b0;
      fault_o     <= 1'b0;
      err_count_o <= '0;
      armed_o     <= 1'b0;
    end else begin
      mismatch_o <= 1'b0;
      case (state_q)
        ST_ARM: begin
          if (err_clr_i) err_count_o <= '0;
          if (arm_cnt_q == ARM_LAST) begin
            state_q <= ST_CHECK;
            armed_o <= 1'b1;
          end else begin
            arm_cnt_q <= arm_cnt_q + 1'b1;
          end
        end

        ST_CHECK, ST_FAULT: begin
          mismatch_o <= raw_mismatch;
          // A mismatch always wins over a concurrent clear.
          if (raw_mismatch) begin
            state_q <= ST_FAULT;
            fault_o <= 1'b1;
          end else if (err_clr_i) begin
            state_q <= ST_CHECK;
            fault_o <= 1'b0;
          end

          if (err_clr_i) begin
            err_count_o <= raw_mismatch ? ERR_CNT_W'(1) : '0;
          end else if (raw_mismatch && (err_count_o != CNT_MAX)) begin
            err_count_o <= err_count_o + 1'b1;
          end
        end

        default: begin
          state_q   <= ST_ARM;
          arm_cnt_q <= '0;
          armed_o   <= 1'b0;
          fault_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcls_compare.sv
// -----------------------------------------------------------------------------
// tb_dcls_compare -- self-checking bench for dcls_compare (DCLS_DELAY=2,
// ERR_CNT_W=4). A behavioural model tracks the history of main-bus samples,
// the number of cycles since reset release and the fault/counter rules, and
// is compared against the DUT after every clock edge.
// -----------------------------------------------------------------------------
module tb_dcls_compare;
  import dcls_pkg::*;

  localparam int DLY     = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic [CMP_W-1:0] main_bus;
  logic [CMP_W-1:0] shadow_bus;
  logic             err_clr;
  logic             inject;
  logic             mismatch;
  logic             fault;
  logic [CNT_W-1:0] err_count;
  logic             armed;

  always #5 clk = ~clk;

  dcls_compare #(
    .DCLS_DELAY (DLY),
    .ERR_CNT_W  (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .main_bus_i   (main_bus),
    .shadow_bus_i (shadow_bus),
    .err_clr_i    (err_clr),
    .inject_i     (inject),
    .mismatch_o   (mismatch),
    .fault_o      (fault),
    .err_count_o  (err_count),
    .armed_o      (armed)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [CMP_W-1:0] m_hist [DLY];   // m_hist[0] = newest main sample
  int               m_since;        // edges seen with reset released
  logic             m_mm, m_fault, m_armed;
  int               m_cnt;
  logic [CMP_W-1:0] wr_err;         // mem_d_wr 0xF ^ 0xC = 0x3

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic clr, input logic inj,
                            input logic [CMP_W-1:0] main, input logic [CMP_W-1:0] shadow);
    logic [CMP_W-1:0] dly;
    logic             cmp_on;
    logic             mm;
    if (!rst) begin
      for (int i = 0; i < DLY; i++) m_hist[i] = '0;
      m_since = 0; m_mm = 0; m_fault = 0; m_cnt = 0; m_armed = 0;
      return;
    end
    dly = m_hist[DLY-1];
`ifdef DCLS_FAULT_INJECT_EN
    if (inj) dly[0] = ~dly[0];
`else
    if (inj) dly = dly;  // injection not built: request has no effect
`endif
    cmp_on = (m_since >= DLY + 1);
    mm     = cmp_on && (dly != shadow);
    if (cmp_on) begin
      if (mm)       m_fault = 1'b1;
      else if (clr) m_fault = 1'b0;
    end
    if (clr)     m_cnt = mm ? 1 : 0;
    else if (mm) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    m_mm = mm;
    if (m_since < 1000) m_since++;
    m_armed = (m_since >= DLY + 1);
    for (int i = DLY - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = main;
  endtask

  // One clock cycle: drive inputs, clock, update model, compare all outputs.
  task automatic step(input logic rst, input logic clr, input logic inj,
                      input logic err, input logic [CMP_W-1:0] rmask, input logic fix_wr);
    dcls_bus_t b;
    b = dcls_bus_t'(CMP_W'({$urandom(), $urandom(), $urandom(), $urandom()}));
    if (fix_wr) b.mem_d_wr = 4'hF;
    main_bus   = b;
    shadow_bus = m_hist[DLY-1] ^ (err ? wr_err : '0) ^ rmask;
    rst_ni     = rst;
    err_clr    = clr;
    inject     = inj;
    @(posedge clk);
    model_edge(rst, clr, inj, main_bus, shadow_bus);
    #1;
    check("mismatch_o",  32'(mismatch),  32'(m_mm));
    check("fault_o",     32'(fault),     32'(m_fault));
    check("err_count_o", 32'(err_count), 32'(m_cnt));
    check("armed_o",     32'(armed),     32'(m_armed));
  endtask

  task automatic quiet(input logic err);
    step(1'b1, 1'b0, 1'b0, err, '0, 1'b1);
  endtask

  typedef struct {
    logic rst, clr, err;
    logic mm, flt, arm;
    int   cnt;
  } vec_t;

  vec_t tbl [18];

  initial begin
    dcls_bus_t t;
    logic      exp_inj;
    t = '0;
    t.mem_d_wr = 4'hC;
    wr_err = t;
    for (int i = 0; i < DLY; i++) m_hist[i] = '0;
    m_since = 0; m_mm = 0; m_fault = 0; m_cnt = 0; m_armed = 0;
    rst_ni = 1'b0; err_clr = 1'b0; inject = 1'b0;
    main_bus = '0; shadow_bus = '0;

    //          rst   clr   err   mm    flt   arm   cnt
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};  // reset values
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};  // ARM 1
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};  // ARM 2
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};  // ARM 3 -> CHECK
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};  // clean compare
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1};  // wr 0xF vs 0x3
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};  // fault sticky
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1};  // clr + mismatch
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};  // clean clr
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};  // reset mid-fault
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};  // ARM ignores diff
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1};  // first compare
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].clr, 1'b0, tbl[i].err, '0, 1'b1);
      check($sformatf("tbl%0d_mismatch", i), 32'(mismatch),  32'(tbl[i].mm));
      check($sformatf("tbl%0d_fault", i),    32'(fault),     32'(tbl[i].flt));
      check($sformatf("tbl%0d_count", i),    32'(err_count), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_armed", i),    32'(armed),     32'(tbl[i].arm));
    end

    // 100 cycles of identical (lagged) buses after reset release.
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      if (i == 1) check("clean_armed_early", 32'(armed), 32'd0);
      if (i == 2) check("clean_armed_on", 32'(armed), 32'd1);
    end
    check("clean_mismatch", 32'(mismatch), 32'd0);
    check("clean_count", 32'(err_count), 32'd0);

    // Saturation: 20 consecutive mismatches stop at 15.
    for (int i = 0; i < 20; i++) quiet(1'b1);
    check("sat_count", 32'(err_count), 32'd15);
    check("sat_mismatch", 32'(mismatch), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("sat_clr_count", 32'(err_count), 32'd0);
    check("sat_clr_fault", 32'(fault), 32'd0);

    // Fault injection with matching buses.
    quiet(1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1);
`ifdef DCLS_FAULT_INJECT_EN
    exp_inj = 1'b1;
`else
    exp_inj = 1'b0;
`endif
    check("inj_mismatch", 32'(mismatch), 32'(exp_inj));
    check("inj_fault", 32'(fault), 32'(exp_inj));
    quiet(1'b0);
    check("inj_pulse_end", 32'(mismatch), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Reset for one cycle during FAULT with count 7.
    for (int i = 0; i < 7; i++) quiet(1'b1);
    quiet(1'b0);
    check("pre_rst_count", 32'(err_count), 32'd7);
    check("pre_rst_fault", 32'(fault), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b1);
    check("rst_all_zero", {28'd0, mismatch, fault, armed, 1'b0} | 32'(err_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      quiet(1'b1);
      check($sformatf("rearm%0d_mismatch", i), 32'(mismatch), 32'd0);
      check($sformatf("rearm%0d_count", i), 32'(err_count), 32'd0);
    end
    quiet(1'b1);
    check("rearm_compare", 32'(mismatch), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [CMP_W-1:0] rm;
      rm = '0;
      if ($urandom_range(0, 7) == 0) rm = CMP_W'(1) << $urandom_range(0, CMP_W - 1);
      step($urandom_range(0, 59) != 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 14) == 0, 1'b0, rm, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcls_compare.md
DCLS_COMPARE -- requirements
Module: dcls_compare

Interface
REQ-001 Clock/reset: one clock clk_i; reset rst_ni is synchronous and active-low.
REQ-002 Parameter DCLS_DELAY, default 2: main-to-shadow lag in cycles, legal range >=1.
REQ-003 Parameter ERR_CNT_W, default 8: mismatch counter width.
REQ-004 clk_i  in  1  clock.
REQ-005 rst_ni  in  1  synchronous active-low reset.
REQ-006 main_bus_i  in  CMP_W  packed main-core outputs: {mem_d_addr 32, mem_d_data_wr 32, mem_d_rd 1, mem_d_wr 4, mem_i_rd 1, mem_i_pc 32}, MSB first; CMP_W=102.
REQ-007 shadow_bus_i  in  CMP_W  shadow-core outputs, same packing.
REQ-008 err_clr_i  in  1  clear fault and counter.
REQ-009 inject_i  in  1  fault-injection request (DCLS_FAULT_INJECT_EN only).
REQ-010 mismatch_o  out  1  registered per-cycle mismatch flag.
REQ-011 fault_o  out  1  sticky fault flag.
REQ-012 err_count_o  out  ERR_CNT_W  saturating mismatch count.
REQ-013 armed_o  out  1  high while comparing (CHECK or FAULT).

Function
REQ-014 main_bus_i shall pass through a DCLS_DELAY-stage register chain; stage outputs zero while in reset.
REQ-015 States: ARM, CHECK, FAULT; ARM holds for exactly DCLS_DELAY+1 cycles after rst_ni rises, then CHECK.
REQ-016 In ARM no comparison occurs; mismatch_o=0, counter unchanged.
REQ-017 In CHECK/FAULT, compare delayed main against shadow_bus_i bitwise every cycle; mismatch_o asserts the next cycle (DCLS_DELAY+1 cycles after the main sample).
REQ-018 CHECK -> FAULT on any mismatch; fault_o rises with mismatch_o, same cycle.
REQ-019 FAULT persists until err_clr_i; err_clr_i without a concurrent mismatch -> CHECK, fault_o=0, counter=0.
REQ-020 err_clr_i together with a mismatch: mismatch wins; stay/enter FAULT, counter=1.
REQ-021 err_clr_i in ARM or CHECK clears counter only; state unchanged.
REQ-022 Counter increments by 1 per mismatch cycle in CHECK/FAULT; saturates at all-ones, no wrap.
REQ-023 rst_ni low at any time, including mid-fault, aborts to ARM on the next edge.

Reset
REQ-024 Reset values: mismatch_o=0, fault_o=0, err_count_o=0, armed_o=0, state=ARM, delay chain=0, arm counter=0.
REQ-025 All outputs registered; no combinational input-to-output path.

Configuration
REQ-026 Macro DCLS_FAULT_INJECT_EN defined: inject_i high inverts bit 0 of delayed main bus in that cycle's comparison only (mem_i_pc LSB).
REQ-027 Macro undefined: inject_i port present but ignored; no injection logic synthesized.

Structure
REQ-028 Package dcls_pkg holds CMP_W, field offsets/widths, and the state enum type.
REQ-029 Delay chain is a sub-module dcls_delay_line (params WIDTH, DEPTH), instantiated once.

Verification
REQ-030 Reset release, identical buses (main=shadow delayed 2): armed_o high at cycle 4, mismatch_o=0, err_count_o=0 for 100 cycles.
REQ-031 Shadow mem_d_wr differs (0xF vs 0x3) for 1 cycle in CHECK -> mismatch_o one pulse, fault_o=1 sticky, err_count_o=1.
REQ-032 ERR_CNT_W=4, 20 consecutive mismatches -> err_count_o stops at 15.
REQ-033 In FAULT, err_clr_i with matching buses -> next cycle fault_o=0, err_count_o=0, CHECK; with concurrent mismatch -> fault_o=1, err_count_o=1.
REQ-034 DCLS_FAULT_INJECT_EN set, inject_i pulse with matching buses -> mismatch_o pulse, fault_o=1; undefined -> no response.
REQ-035 rst_ni low one cycle during FAULT with err_count_o=7 -> all outputs zero, ARM re-entered, no compare for 3 cycles.
